// File: rtl/uart_byte_buffer.sv
// UART byte buffer: packs LSB-first receiver bits into bytes and queues
// them in a first-word-fall-through FIFO with overflow and timeout flags.
module uart_byte_buffer #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bit_i,
    input  logic                        is_new,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow,
    input  logic                        ovf_clr,
    output logic                        frame_err
);
    localparam int TIMEOUT = 3 * (CLK_FREQ / BAUD_RATE);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LAST = 3'd7;

    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem [FIFO_DEPTH];

    logic       in_asm;
    logic       push;
    logic       timeout;
    logic [7:0] push_data;
    logic       pop;
    logic       full;
    logic       accept;
    logic       drop;

    assign in_asm    = (bit_cnt_q != S_IDLE);
    assign push_data = {bit_i, shift_q[7:1]};

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        idle_d    = idle_q;
        push      = 1'b0;
        timeout   = 1'b0;
        if (is_new) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = push_data;
            idle_d    = '0;
            if (bit_cnt_q == S_LAST) begin
                push    = 1'b1;
                shift_d = '0;
            end
        end else if (in_asm) begin
            // a stalled partial byte is abandoned once the gap reaches TIMEOUT
            if (idle_q == TMO) begin
                timeout   = 1'b1;
                bit_cnt_d = S_IDLE;
                shift_d   = '0;
                idle_d    = '0;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end else begin
            idle_d = '0;
        end
    end

    assign out_valid = (level_q != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (level_q == FULL_LVL);
    assign accept    = push && (!full || pop);
    assign drop      = push && !accept;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        if (accept) wptr_d = wptr_q + AW'(1);
        if (pop)    rptr_d = rptr_q + AW'(1);
        if (accept && !pop)      level_d = level_q + LW'(1);
        else if (pop && !accept) level_d = level_q - LW'(1);
        if (drop)         ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q <= S_IDLE;
            shift_q   <= '0;
            idle_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            idle_q    <= idle_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
        end
    end

    // storage needs no reset; out_data is gated by out_valid
    always_ff @(posedge clk) begin
        if (accept) mem[wptr_q] <= push_data;
    end

    assign out_data  = out_valid ? mem[rptr_q] : 8'h00;
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign frame_err = timeout;
endmodule

// File: tb/tb_uart_byte_buffer.sv
// Self-checking bench for uart_byte_buffer: directed table, corner
// sequences and random traffic against a queue-based reference model.
module tb_uart_byte_buffer;
    localparam int CLK_FREQ  = 40;
    localparam int BAUD_RATE = 4;
    localparam int DEPTH     = 4;
    localparam int TIMEOUT   = 3 * (CLK_FREQ / BAUD_RATE);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_i = 1'b0;
    logic       is_new = 1'b0;
    logic       out_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] level;
    logic       overflow;
    logic       frame_err;

    uart_byte_buffer #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bit_i    (bit_i),
        .is_new   (is_new),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // reference model state
    logic [7:0] q[$];
    logic [7:0] acc;
    int         nbits;
    int         idle;
    logic       m_ovf;

    int fe_cnt;
    int vcnt;
    int maxl;

    typedef struct {
        logic       b;
        logic       nw;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] el;
        logic       eo;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        acc   = 8'h00;
        nbits = 0;
        idle  = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_update(input logic b, input logic nw,
                                input logic rdy, input logic clr);
        logic       got;
        logic       dropped;
        logic [7:0] nb;
        got     = 1'b0;
        dropped = 1'b0;
        nb      = 8'h00;
        if (nw) begin
            acc[nbits] = b;
            nbits++;
            idle = 0;
            if (nbits == 8) begin
                got   = 1'b1;
                nb    = acc;
                acc   = 8'h00;
                nbits = 0;
            end
        end else if (nbits > 0) begin
            if (idle >= TIMEOUT) begin
                nbits = 0;
                acc   = 8'h00;
                idle  = 0;
            end else begin
                idle++;
            end
        end
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (got) begin
            if (q.size() < DEPTH) q.push_back(nb);
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic step(input logic b, input logic nw,
                        input logic rdy, input logic clr);
        @(negedge clk);
        bit_i     = b;
        is_new    = nw;
        out_ready = rdy;
        ovf_clr   = clr;
        #1;
        chk("out_valid", out_valid, q.size() != 0);
        chk("out_data", out_data, (q.size() != 0) ? q[0] : 8'h00);
        chk("level", level, q.size());
        chk("overflow", overflow, m_ovf);
        chk("frame_err", frame_err,
            (nbits > 0) && (idle >= TIMEOUT) && !nw);
        if (frame_err) fe_cnt++;
        if (out_valid) vcnt++;
        if (int'(level) > maxl) maxl = int'(level);
        @(posedge clk);
        model_update(b, nw, rdy, clr);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic rdy_mid,
                             input logic rdy_last, input logic clr_last);
        for (int i = 0; i < 8; i++)
            step(v[i], 1'b1, (i == 7) ? rdy_last : rdy_mid,
                 (i == 7) ? clr_last : 1'b0);
    endtask

    task automatic idle_step(input logic rdy);
        step(1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        is_new    = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_level", level, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] bits36;
        logic [7:0] exp39 [4];
        logic       nw;
        logic       rdy;
        logic       clr;
        int         mode;

        model_reset();
        fe_cnt = 0;
        vcnt   = 0;
        maxl   = 0;
        mode   = 0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_level", level, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 8'h00);
        chk("reset_ovf", overflow, 0);
        chk("reset_ferr", frame_err, 0);
        @(negedge clk);
        rst = 1'b1;

        // directed table: bits 1,0,1,1,1,0,0,0 -> 8'h1D, then pop
        bits36 = 8'h1D;
        for (int i = 0; i < 8; i++) begin
            tbl[i].b   = bits36[i];
            tbl[i].nw  = 1'b1;
            tbl[i].rdy = 1'b0;
            tbl[i].clr = 1'b0;
            tbl[i].ev  = (i == 7);
            tbl[i].ed  = (i == 7) ? 8'h1D : 8'h00;
            tbl[i].el  = (i == 7) ? 3'd1 : 3'd0;
            tbl[i].eo  = 1'b0;
        end
        tbl[8] = '{b: 1'b0, nw: 1'b0, rdy: 1'b1, clr: 1'b0,
                   ev: 1'b0, ed: 8'h00, el: 3'd0, eo: 1'b0};
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].b, tbl[i].nw, tbl[i].rdy, tbl[i].clr);
            #1;
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].el);
            chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].eo);
        end

        // fill past full, drop with clear in same cycle, drain, clear
        for (int v = 1; v <= 5; v++) send_byte(8'(v), 1'b0, 1'b0, 1'b0);
        #1;
        chk("full_level", level, 4);
        chk("full_ovf", overflow, 1);
        send_byte(8'h06, 1'b0, 1'b0, 1'b1);
        #1;
        chk("set_wins_ovf", overflow, 1);
        chk("set_wins_level", level, 4);
        for (int v = 1; v <= 4; v++) begin
            #1;
            chk("drain_data", out_data, v);
            idle_step(1'b1);
        end
        #1;
        chk("drained_level", level, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("ovf_cleared", overflow, 0);

        // timeout after 3 bits
        fe_cnt = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (TIMEOUT + 5) idle_step(1'b0);
        chk("timeout_pulses", fe_cnt, 1);
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        #1;
        chk("after_timeout_data", out_data, 8'hA5);
        chk("after_timeout_level", level, 1);
        idle_step(1'b1);

        // push and pop on the same edge while full
        send_byte(8'h10, 1'b0, 1'b0, 1'b0);
        send_byte(8'h20, 1'b0, 1'b0, 1'b0);
        send_byte(8'h30, 1'b0, 1'b0, 1'b0);
        send_byte(8'h40, 1'b0, 1'b0, 1'b0);
        send_byte(8'h50, 1'b0, 1'b1, 1'b0);
        #1;
        chk("pp_level", level, 4);
        chk("pp_ovf", overflow, 0);
        exp39[0] = 8'h20;
        exp39[1] = 8'h30;
        exp39[2] = 8'h40;
        exp39[3] = 8'h50;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("pp_order", out_data, exp39[k]);
            idle_step(1'b1);
        end

        // reset mid-assembly with two bytes queued
        send_byte(8'h11, 1'b0, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("pre_rst_level", level, 2);
        async_reset();
        send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post_rst_data", out_data, 8'h3C);
        chk("post_rst_level", level, 1);
        idle_step(1'b1);

        // streaming with out_ready held high
        vcnt = 0;
        maxl = 0;
        send_byte(8'hC3, 1'b1, 1'b1, 1'b0);
        send_byte(8'h5A, 1'b1, 1'b1, 1'b0);
        send_byte(8'h96, 1'b1, 1'b1, 1'b0);
        repeat (3) idle_step(1'b1);
        chk("stream_valid_cycles", vcnt, 3);
        chk("stream_max_level", maxl <= 1, 1);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) mode = $urandom_range(0, 3);
            case (mode)
                0: nw = 1'($urandom_range(0, 1));
                1: nw = ($urandom_range(0, 7) == 0);
                2: nw = 1'b0;
                default: nw = 1'b1;
            endcase
            if (mode == 3) rdy = ($urandom_range(0, 3) == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 19) == 0);
            step(1'($urandom_range(0, 1)), nw, rdy, clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/uart_byte_buffer.md
UART_BYTE_BUFFER -- requirements
Module: uart_byte_buffer

Interface
REQ-001 Parameter: CLK_FREQ, 100_000_000, system clock frequency in Hz.
REQ-002 Parameter: BAUD_RATE, 115_200, serial line rate in baud.
REQ-003 Parameter: FIFO_DEPTH, 16, byte FIFO depth; power of two, at least 2.
REQ-004 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset.
REQ-006 Port: bit  input  1  data bit from the UART receiver; valid only while is_new=1.
REQ-007 Port: is_new  input  1  one-cycle strobe, once per received data bit, 8 per frame, LSB first.
REQ-008 Port: out_data  output  8  FIFO head byte; valid while out_valid=1.
REQ-009 Port: out_valid  output  1  FIFO non-empty.
REQ-010 Port: out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 Port: level  output  $clog2(FIFO_DEPTH)+1  number of bytes held.
REQ-012 Port: overflow  output  1  sticky flag; a completed byte was dropped.
REQ-013 Port: ovf_clr  input  1  one-cycle pulse that clears overflow.
REQ-014 Port: frame_err  output  1  one-cycle pulse; partial byte discarded on timeout.

Function
REQ-015 Assembler SHALL have two states: IDLE (bit_cnt=0) and ASSEMBLE (bit_cnt 1..7).
REQ-016 Each is_new SHALL shift bit in LSB-first, so the first bit becomes byte bit 0, and increment bit_cnt.
REQ-017 The 8th is_new SHALL complete the byte, return bit_cnt to 0 (IDLE) and request a push at that same edge.
REQ-018 Idle counter SHALL clear on every is_new and otherwise increment while in ASSEMBLE, saturating.
REQ-019 Timeout: TIMEOUT = 3*(CLK_FREQ/BAUD_RATE) cycles, integer division.
REQ-020 When the idle counter reaches TIMEOUT in ASSEMBLE, the block SHALL clear bit_cnt and the shift register and pulse frame_err for exactly one cycle.
REQ-021 If is_new and timeout coincide, is_new SHALL win: the bit is accepted, no frame_err, counter cleared.
REQ-022 In IDLE the idle counter SHALL be held at 0 and frame_err SHALL NOT assert.
REQ-023 FIFO SHALL be first-word-fall-through: out_data = oldest byte, out_valid = (level != 0).
REQ-024 Latency: a byte completed at edge N into an empty FIFO SHALL appear on out_data/out_valid after edge N, i.e. one cycle later.
REQ-025 Pop SHALL occur when out_valid && out_ready at a clock edge; out_ready while empty has no effect.
REQ-026 Push SHALL be accepted if level < FIFO_DEPTH, or if a pop occurs in the same cycle.
REQ-027 Simultaneous push and pop SHALL leave level unchanged at any fill level, including full.
REQ-028 A push refused at full (no pop that cycle) SHALL drop the byte, set overflow, and leave FIFO contents and level unchanged.
REQ-029 ovf_clr SHALL clear overflow; if a drop occurs in the same cycle, set SHALL win.
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL reach exactly FIFO_DEPTH when full.
REQ-031 Byte order out SHALL equal completion order; no byte SHALL be duplicated or reordered.

Reset
REQ-032 rst=0 SHALL asynchronously force: bit_cnt=0, shift register=0, idle counter=0, pointers=0, level=0, out_valid=0, overflow=0, frame_err=0.
REQ-033 out_data SHALL read 8'h00 during reset.
REQ-034 Reset mid-assembly SHALL discard the partial byte; the first is_new after release SHALL be treated as bit 0.
REQ-035 Reset deassertion SHALL be synchronous to clk; the first active edge is the first edge with rst=1.

Verification
REQ-036 Bits 1,0,1,1,1,0,0,0 via is_new, out_ready=0 -> one cycle after the 8th strobe: out_valid=1, out_data=8'h1D, level=1.
REQ-037 FIFO_DEPTH=4, out_ready=0, bytes 8'h01..8'h05 -> level=4 and overflow=1 after the 5th; drain yields 01,02,03,04; ovf_clr -> overflow=0.
REQ-038 3 bits, then no is_new for TIMEOUT cycles -> one frame_err pulse, bit_cnt=0; next 8 bits 8'hA5 -> out_data=8'hA5.
REQ-039 FIFO full (4), out_ready=1 on the same cycle a 5th byte completes -> level stays 4, overflow=0, 5th byte emerges last.
REQ-040 Assert rst mid-assembly (5 bits) with level=2 -> immediately level=0, out_valid=0; after release, 8 bits 8'h3C -> out_data=8'h3C.
REQ-041 out_ready held at 1, stream of 3 bytes -> each byte shows out_valid for exactly one cycle, level never exceeds 1.
